// File: rtl/bp_io_reg_endpoint.sv
// Uncached BedRock IO endpoint: one outstanding command serviced against a small
// local register file. Define BP_IO_REG_CYCLE_COUNTER_EN to make reg[0] a read-only cycle counter.
module bp_io_reg_endpoint #(
  parameter int unsigned addr_width_p    = 40,
  parameter int unsigned data_width_p    = 64,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned num_regs_p      = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [3:0]                 io_cmd_type_i,
  input  logic [addr_width_p-1:0]    io_cmd_addr_i,
  input  logic [2:0]                 io_cmd_size_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic [data_width_p-1:0]    io_cmd_data_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_and_o,
  output logic [3:0]                 io_resp_type_o,
  output logic [addr_width_p-1:0]    io_resp_addr_o,
  output logic [2:0]                 io_resp_size_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic [data_width_p-1:0]    io_resp_data_o,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i
);

  localparam int unsigned idx_w = $clog2(num_regs_p);

  localparam logic [3:0] uc_rd_type = 4'd2;
  localparam logic [3:0] uc_wr_type = 4'd3;

  localparam logic [0:0] e_ready = 1'b0;
  localparam logic [0:0] e_resp  = 1'b1;

  logic [0:0]              state;
  logic [data_width_p-1:0] regs [num_regs_p];

  logic                    accept;
  logic                    is_rd;
  logic                    is_wr;
  logic                    wr_en;
  logic [idx_w-1:0]        idx;
  logic [1:0]              size_eff;
  logic [7:0]              low_mask;
  logic [2:0]              align;
  logic [2:0]              off;
  logic [7:0]              lane_mask;
  logic [data_width_p-1:0] wdata_sh;
  logic [data_width_p-1:0] read_bits;
  logic [data_width_p-1:0] cur;
  logic [data_width_p-1:0] rdata;

  assign accept = io_cmd_v_i & (state == e_ready);
  assign is_rd  = (io_cmd_type_i == uc_rd_type);
  assign is_wr  = (io_cmd_type_i == uc_wr_type);
  assign idx    = io_cmd_addr_i[3 +: idx_w];

  // sizes 4..7 behave as full 8-byte accesses
  assign size_eff = io_cmd_size_i[2] ? 2'd3 : io_cmd_size_i[1:0];

  always_comb begin
    low_mask = 8'hFF;
    align    = 3'b000;
    case (size_eff)
      2'd0: begin low_mask = 8'h01; align = 3'b111; end
      2'd1: begin low_mask = 8'h03; align = 3'b110; end
      2'd2: begin low_mask = 8'h0F; align = 3'b100; end
      default: begin low_mask = 8'hFF; align = 3'b000; end
    endcase
  end

  assign off       = io_cmd_addr_i[2:0] & align;
  assign lane_mask = low_mask << off;
  assign wdata_sh  = io_cmd_data_i << {off, 3'b000};

  always_comb begin
    read_bits = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      read_bits[8*i +: 8] = {8{low_mask[i]}};
    end
  end

`ifdef BP_IO_REG_CYCLE_COUNTER_EN
  logic [data_width_p-1:0] counter;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // index 0 is the counter: reads see it, writes are answered but dropped
  assign cur   = (idx == '0) ? counter : regs[idx];
  assign wr_en = accept & is_wr & (idx != '0);
`else
  assign cur   = regs[idx];
  assign wr_en = accept & is_wr;
`endif

  assign rdata = (cur >> {off, 3'b000}) & read_bits;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned r = 0; r < num_regs_p; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (lane_mask[i]) begin
          regs[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= e_ready;
    end else begin
      case (state)
        e_ready: if (io_cmd_v_i)     state <= e_resp;
        e_resp:  if (io_resp_yumi_i) state <= e_ready;
        default: state <= e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      io_resp_type_o    <= '0;
      io_resp_addr_o    <= '0;
      io_resp_size_o    <= '0;
      io_resp_payload_o <= '0;
      io_resp_data_o    <= '0;
    end else if (accept) begin
      io_resp_type_o    <= io_cmd_type_i;
      io_resp_addr_o    <= io_cmd_addr_i;
      io_resp_size_o    <= io_cmd_size_i;
      io_resp_payload_o <= io_cmd_payload_i;
      io_resp_data_o    <= is_rd ? rdata : '0;
    end
  end

  assign io_cmd_ready_and_o = (state == e_ready);
  assign io_resp_v_o        = (state == e_resp);

endmodule

// File: tb/tb_bp_io_reg_endpoint.sv
// Directed bench for bp_io_reg_endpoint with a byte-array reference model
// checked against the response channel on every cycle.
module tb_bp_io_reg_endpoint;

  localparam int unsigned AW = 40;
  localparam int unsigned PW = 16;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    cmd_type = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_size = '0;
  logic [PW-1:0] cmd_payload = '0;
  logic [63:0]   cmd_data = '0;
  logic          cmd_v = 1'b0;
  logic          ready;
  logic [3:0]    resp_type;
  logic [AW-1:0] resp_addr;
  logic [2:0]    resp_size;
  logic [PW-1:0] resp_payload;
  logic [63:0]   resp_data;
  logic          resp_v;
  logic          yumi = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bp_io_reg_endpoint #(
    .addr_width_p(AW),
    .data_width_p(64),
    .payload_width_p(PW),
    .num_regs_p(NR)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .io_cmd_type_i(cmd_type),
    .io_cmd_addr_i(cmd_addr),
    .io_cmd_size_i(cmd_size),
    .io_cmd_payload_i(cmd_payload),
    .io_cmd_data_i(cmd_data),
    .io_cmd_v_i(cmd_v),
    .io_cmd_ready_and_o(ready),
    .io_resp_type_o(resp_type),
    .io_resp_addr_o(resp_addr),
    .io_resp_size_o(resp_size),
    .io_resp_payload_o(resp_payload),
    .io_resp_data_o(resp_data),
    .io_resp_v_o(resp_v),
    .io_resp_yumi_i(yumi)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as byte arrays, counter as a plain integer.
  byte unsigned    mem [NR][8];
  longint unsigned mcnt;
  bit              pend;
  logic [3:0]      e_type;
  logic [AW-1:0]   e_addr;
  logic [2:0]      e_size;
  logic [PW-1:0]   e_payload;
  logic [63:0]     e_data;
  bit              m_acc;
  int              m_n, m_o, m_ix;
  logic [63:0]     m_v;
  bit              m_cnt_reg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < 8; b++) mem[r][b] = 8'h00;
      mcnt = 0; pend = 0;
      e_type = '0; e_addr = '0; e_size = '0; e_payload = '0; e_data = '0;
    end else begin
      m_acc = !pend && cmd_v;
      if (pend && yumi) pend = 0;
      if (m_acc) begin
        m_n  = 1 << ((cmd_size > 3) ? 3 : int'(cmd_size));
        m_o  = (int'(cmd_addr[2:0]) / m_n) * m_n;
        m_ix = int'((cmd_addr >> 3) % NR);
`ifdef BP_IO_REG_CYCLE_COUNTER_EN
        m_cnt_reg = (m_ix == 0);
`else
        m_cnt_reg = 0;
`endif
        m_v = '0;
        for (int k = 0; k < m_n; k++) begin
          if (m_cnt_reg) m_v = m_v | (((mcnt >> (8 * (m_o + k))) & 64'hFF) << (8 * k));
          else           m_v = m_v | (64'(mem[m_ix][m_o + k]) << (8 * k));
        end
        e_data = (cmd_type == 4'd2) ? m_v : 64'h0;
        if (cmd_type == 4'd3 && !m_cnt_reg)
          for (int k = 0; k < m_n; k++) mem[m_ix][m_o + k] = cmd_data[8*k +: 8];
        e_type = cmd_type; e_addr = cmd_addr; e_size = cmd_size; e_payload = cmd_payload;
        pend = 1;
      end
      mcnt = mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_and", 64'(ready), 64'(!pend));
      check("resp_v", 64'(resp_v), 64'(pend));
      if (pend) begin
        check("resp_type", 64'(resp_type), 64'(e_type));
        check("resp_addr", 64'(resp_addr), 64'(e_addr));
        check("resp_size", 64'(resp_size), 64'(e_size));
        check("resp_payload", 64'(resp_payload), 64'(e_payload));
        check("resp_data", resp_data, e_data);
      end
    end
  end

  task automatic issue(input logic [3:0] t, input logic [AW-1:0] a, input logic [2:0] s,
                       input logic [PW-1:0] p, input logic [63:0] d);
    cmd_type = t; cmd_addr = a; cmd_size = s; cmd_payload = p; cmd_data = d; cmd_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk); #1;
        cmd_v = 1'b0;
        return;
      end
    end
    compared++; mismatched++;
    $display("FAIL accept_timeout: got no ready_and, required ready_and within 20 cycles");
    cmd_v = 1'b0;
  endtask

  task automatic finish_resp(input int delay, output logic [63:0] d, output logic [PW-1:0] p,
                             output logic [3:0] t);
    bit ok = 0;
    d = '0; p = '0; t = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_v) begin ok = 1; break; end
    end
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL resp_timeout: got no resp_v, required resp_v within 20 cycles");
      return;
    end
    d = resp_data; p = resp_payload; t = resp_type;
    repeat (delay) @(negedge clk);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] t, input logic [AW-1:0] a, input logic [2:0] s,
                        input logic [PW-1:0] p, input logic [63:0] d, input int delay,
                        output logic [63:0] rd, output logic [PW-1:0] rp, output logic [3:0] rt);
    issue(t, a, s, p, d);
    finish_resp(delay, rd, rp, rt);
  endtask

  logic [63:0]   d, d1, d2, d3;
  logic [PW-1:0] p;
  logic [3:0]    t;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_resp_v", 64'(resp_v), 64'h0);
    check("reset_ready", 64'(ready), 64'h1);
    check("reset_resp_addr", 64'(resp_addr), 64'h0);
    @(posedge clk); #1;

    do_cmd(4'd2, 40'h10, 3'd3, 16'h0001, 64'h0, 0, d, p, t);
    check("rd_idle_0x10", d, 64'h0);

    do_cmd(4'd3, 40'h08, 3'd3, 16'hBEEF, 64'h1122334455667788, 0, d, p, t);
    check("wr_resp_data", d, 64'h0);
    do_cmd(4'd2, 40'h08, 3'd3, 16'hBEEF, 64'h0, 0, d, p, t);
    check("rd_full", d, 64'h1122334455667788);
    check("payload_echo", 64'(p), 64'hBEEF);

    do_cmd(4'd3, 40'h0D, 3'd0, 16'h0002, 64'hAA, 0, d, p, t);
    do_cmd(4'd2, 40'h08, 3'd3, 16'h0003, 64'h0, 0, d, p, t);
    check("rd_after_byte_wr", d, 64'h1122AA4455667788);
    do_cmd(4'd2, 40'h0C, 3'd1, 16'h0004, 64'h0, 0, d, p, t);
    check("rd_half_0x0C", d, 64'hAA44);
    do_cmd(4'd2, 40'h0B, 3'd2, 16'h0005, 64'h0, 0, d, p, t);
    check("rd_word_misaligned", d, 64'h55667788);
    do_cmd(4'd2, 40'h0F, 3'd5, 16'h0006, 64'h0, 0, d, p, t);
    check("rd_size5_as_8B", d, 64'h1122AA4455667788);
    do_cmd(4'd2, 40'h48, 3'd3, 16'h0007, 64'h0, 0, d, p, t);
    check("rd_alias_0x48", d, 64'h1122AA4455667788);
    do_cmd(4'd2, 40'h0F, 3'd0, 16'h0008, 64'h0, 0, d, p, t);
    check("rd_top_byte", d, 64'h11);
    do_cmd(4'd3, 40'h0B, 3'd1, 16'h0009, 64'hFFFFBEEF, 0, d, p, t);
    do_cmd(4'd2, 40'h08, 3'd3, 16'h000A, 64'h0, 0, d, p, t);
    check("rd_after_half_wr", d, 64'h1122AA44BEEF7788);

    // backpressure with a second command held valid
    cmd_type = 4'd2; cmd_addr = 40'h08; cmd_size = 3'd3; cmd_payload = 16'h1234;
    cmd_data = 64'h0; cmd_v = 1'b1;
    @(negedge clk);
    check("bp_first_ready", 64'(ready), 64'h1);
    @(posedge clk); #1;
    cmd_type = 4'd3; cmd_addr = 40'h10; cmd_payload = 16'h5678; cmd_data = 64'hCAFEF00D12345678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(ready), 64'h0);
      check("bp_data_stable", resp_data, 64'h1122AA44BEEF7788);
      check("bp_payload_stable", 64'(resp_payload), 64'h1234);
    end
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
    @(negedge clk);
    check("bp_ready_after_yumi", 64'(ready), 64'h1);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    @(negedge clk);
    check("bp_second_v", 64'(resp_v), 64'h1);
    check("bp_second_addr", 64'(resp_addr), 64'h10);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
    do_cmd(4'd2, 40'h10, 3'd3, 16'h000B, 64'h0, 0, d, p, t);
    check("rd_second_wr", d, 64'hCAFEF00D12345678);

    do_cmd(4'd0, 40'h00, 3'd3, 16'h000C, 64'hDEADDEADDEADDEAD, 0, d, p, t);
    check("other_data", d, 64'h0);
    check("other_type_echo", 64'(t), 64'h0);
    do_cmd(4'd7, 40'h08, 3'd3, 16'h000D, 64'hFFFFFFFFFFFFFFFF, 1, d, p, t);
    check("other7_type_echo", 64'(t), 64'h7);
    do_cmd(4'd2, 40'h08, 3'd3, 16'h000E, 64'h0, 0, d, p, t);
    check("other_no_change", d, 64'h1122AA44BEEF7788);

`ifdef BP_IO_REG_CYCLE_COUNTER_EN
    do_cmd(4'd2, 40'h00, 3'd3, 16'h0010, 64'h0, 2, d1, p, t);
    do_cmd(4'd2, 40'h00, 3'd3, 16'h0011, 64'h0, 0, d2, p, t);
    check("cnt_delta_4", d2 - d1, 64'h4);
    do_cmd(4'd3, 40'h00, 3'd3, 16'h0012, 64'h0, 0, d, p, t);
    do_cmd(4'd2, 40'h00, 3'd3, 16'h0013, 64'h0, 0, d3, p, t);
    check("cnt_wr_ignored", d3 - d2, 64'h4);
`else
    do_cmd(4'd3, 40'h00, 3'd2, 16'h0010, 64'h87654321, 0, d, p, t);
    do_cmd(4'd2, 40'h04, 3'd3, 16'h0011, 64'h0, 0, d1, p, t);
    check("reg0_ordinary", d1, 64'h87654321);
`endif

    // reset while a response is pending
    issue(4'd2, 40'h08, 3'd3, 16'h0020, 64'h0);
    @(negedge clk);
    check("pre_reset_v", 64'(resp_v), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_v", 64'(resp_v), 64'h0);
    check("reset_clears_data", resp_data, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_cmd(4'd2, 40'h08, 3'd3, 16'h0021, 64'h0, 0, d, p, t);
    check("reg1_cleared", d, 64'h0);
    do_cmd(4'd2, 40'h10, 3'd3, 16'h0022, 64'h0, 0, d, p, t);
    check("reg2_cleared", d, 64'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
